switch_accumulator: RTL and testbench
=====================================

SWITCH_ACCUMULATOR -- requirements
Module: switch_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 8: switch input and accumulator width, 1..32.
REQ-002 SHALL have parameter LED_W, default 8: LED output width, not greater than DATA_W.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000: cycles a key level must be stable before it is accepted, at least 2.
REQ-004 SHALL have port: clk  in  1  single system clock; all logic is in this domain.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: sw  in  DATA_W  switch operand, asynchronous.
REQ-007 SHALL have port: key_accum_n  in  1  accumulate pushbutton, active-low, asynchronous.
REQ-008 SHALL have port: key_clear_n  in  1  clear pushbutton, active-low, asynchronous.
REQ-009 SHALL have port: led  out  LED_W  equal to sum[LED_W-1:0].
REQ-010 SHALL have Avalon-MM slave ports: address in 2; read in 1; write in 1; writedata in 32; readdata out 32.

Function
REQ-011 SHALL pass sw, key_accum_n and key_clear_n each through a 2-flop synchronizer before use.
REQ-012 SHALL debounce each synchronized key with a four-state FSM.
- IDLE -> PRESS_WAIT when the key reads low.
- PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive low cycles; returns to IDLE on any high cycle.
- HELD -> RELEASE_WAIT when the key reads high.
- RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive high cycles; returns to HELD on any low cycle.
REQ-013 SHALL emit exactly one single-cycle event per debounced press, on the PRESS_WAIT -> HELD transition.
REQ-014 SHALL apply an accumulate event to sum in the cycle after the event, as selected by CTRL.mode:
- 0 ADD: sum + sw.
- 1 SUB: sum - sw.
- 2 XOR: sum ^ sw.
- 3: reserved; no operation.
REQ-015 SHALL handle ADD carry-out or SUB borrow as follows:
- CTRL.sat = 0: result wraps modulo 2^DATA_W.
- CTRL.sat = 1: result clamps to 2^DATA_W-1 on ADD and to 0 on SUB.
- In both cases STATUS.ovf is set (sticky).
REQ-016 SHALL never set STATUS.ovf in XOR mode.
REQ-017 SHALL increment STATUS.count (16-bit, wraps 0xFFFF -> 0) on every applied accumulate event.
REQ-018 SHALL, on a clear event, set sum to 0 and count to 0; ovf is left unchanged.
REQ-019 SHALL use this register map; reads of unused bits return 0:
- 0 SUM: read/write DATA_W.
- 1 SW: synchronized sw, read-only.
- 2 CTRL: [1:0] mode, [2] sat; read/write.
- 3 STATUS: [15:0] count, [16] ovf; writing 1 to bit 16 clears ovf.
REQ-020 SHALL return readdata registered, exactly 1 cycle after read is asserted; there are no wait states, and writes take effect on the next edge.
REQ-021 SHALL resolve simultaneous sum updates with priority clear event > bus write to SUM > accumulate event; the losing accumulate is discarded and count does not increment.
REQ-022 SHALL let set win when a W1C clear of ovf coincides with an overflow in the same cycle.

Reset
REQ-023 SHALL, on reset assertion, immediately clear sum, count, ovf, CTRL (mode ADD, sat 0), readdata, led, synchronizers and debounce counters, and put both FSMs in IDLE.
REQ-024 SHALL generate no event from a key held low through reset deassertion until it has been debounced as a new press per REQ-012.

Structure
REQ-025 SHALL define in shared package accum_pkg: the mode enum (ADD, SUB, XOR, RSVD), register address constants and STATUS bit positions.
REQ-026 SHALL implement the synchronizer and FSM of REQ-011/REQ-012 in sub-module key_debounce (parameter DEBOUNCE_CYCLES; outputs press_pulse and level), instantiated twice.

Verification
REQ-027 SHALL run the bench with DATA_W=8 and DEBOUNCE_CYCLES=4, and cover these scenarios:
- Bounce: key_accum_n low 3 cycles, high 1, then low 10, sw=5 -> one event, SUM=5, count=1.
- Wrap: SUM=0xFE, sw=3, ADD, sat=0, press -> SUM=0x01, ovf=1. Same with sat=1 -> SUM=0xFF.
- SUB clamp: SUM=2, sw=5, mode SUB, sat=1, press -> SUM=0, ovf=1. Then write STATUS bit16=1 -> ovf=0.
- Collision: bus write SUM=0x40 in the same cycle as an accumulate event, sw=1 -> SUM=0x40, count unchanged.
- Read latency: read address 1 with sw=0xA5 -> readdata=0x000000A5 exactly one cycle later.
- Reset mid-press: reset asserted during PRESS_WAIT with the key held low through deassertion -> no event; SUM=0, led=0.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared types and register map for the switch accumulator
package accum_pkg;
    typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_XOR, MODE_RSVD} mode_t;
    typedef enum logic [1:0] {DB_IDLE, DB_PRESS_WAIT, DB_HELD, DB_RELEASE_WAIT} db_state_t;
    localparam logic [1:0] ADDR_SUM    = 2'd0;
    localparam logic [1:0] ADDR_SW     = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam int COUNT_W        = 16;
    localparam int STATUS_OVF_BIT = 16;
    localparam int CTRL_SAT_BIT   = 2;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer and four-state debounce FSM for an active-low key
module key_debounce
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic r_meta, r_sync;
    db_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic w_done;
    // synchronizer resets to the released level so reset alone never looks like a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_state <= DB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_meta  <= key_n;
            r_sync  <= r_meta;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    assign w_done = r_cnt == LAST;
    assign level  = (r_state == DB_HELD) || (r_state == DB_RELEASE_WAIT);
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        press_pulse = 1'b0;
        case (r_state)
            DB_IDLE: begin
                w_cnt_nxt = CW'(1);
                if (!r_sync) w_state_nxt = DB_PRESS_WAIT;
            end
            DB_PRESS_WAIT: begin
                if (r_sync) w_state_nxt = DB_IDLE;
                else if (w_done) begin
                    w_state_nxt = DB_HELD;
                    press_pulse = 1'b1;
                end
            end
            DB_HELD: begin
                w_cnt_nxt = CW'(1);
                if (r_sync) w_state_nxt = DB_RELEASE_WAIT;
            end
            DB_RELEASE_WAIT: begin
                if (!r_sync) w_state_nxt = DB_HELD;
                else if (w_done) w_state_nxt = DB_IDLE;
            end
            default: w_state_nxt = DB_IDLE;
        endcase
    end
endmodule

// File: rtl/switch_accumulator.sv
// switch_accumulator: debounced-key driven ADD/SUB/XOR accumulator with an Avalon-MM register slave
module switch_accumulator
    import accum_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int LED_W           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              key_accum_n,
    input  logic              key_clear_n,
    output logic [LED_W-1:0]  led,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
);
    logic [DATA_W-1:0] r_sw_meta, r_sw_sync, r_sum, w_result;
    logic [COUNT_W-1:0] r_count;
    logic r_ovf, r_sat;
    mode_t r_mode;
    logic [31:0] r_readdata, w_rdata;
    logic [DATA_W:0] w_add, w_sub;
    logic w_accum_pulse, w_clear_pulse, w_accum_level, w_clear_level;
    logic w_carry, w_acc, w_wr_sum, w_wr_ctrl, w_w1c, w_unused;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accum (
        .clk(clk), .reset(reset), .key_n(key_accum_n),
        .press_pulse(w_accum_pulse), .level(w_accum_level)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset(reset), .key_n(key_clear_n),
        .press_pulse(w_clear_pulse), .level(w_clear_level)
    );
    assign w_unused  = ^{writedata, w_accum_level, w_clear_level};
    assign w_wr_sum  = write && address == ADDR_SUM;
    assign w_wr_ctrl = write && address == ADDR_CTRL;
    assign w_w1c     = write && address == ADDR_STATUS && writedata[STATUS_OVF_BIT];
    // clear and bus writes to SUM both pre-empt an accumulate in the same cycle
    assign w_acc     = w_accum_pulse && !w_clear_pulse && !w_wr_sum;
    assign w_add     = {1'b0, r_sum} + {1'b0, r_sw_sync};
    assign w_sub     = {1'b0, r_sum} - {1'b0, r_sw_sync};
    assign w_carry   = (r_mode == MODE_ADD && w_add[DATA_W]) || (r_mode == MODE_SUB && w_sub[DATA_W]);
    assign w_result  = (r_mode == MODE_ADD) ? ((r_sat && w_add[DATA_W]) ? '1 : w_add[DATA_W-1:0]) :
                       (r_mode == MODE_SUB) ? ((r_sat && w_sub[DATA_W]) ? '0 : w_sub[DATA_W-1:0]) :
                       (r_mode == MODE_XOR) ? (r_sum ^ r_sw_sync) : r_sum;
    assign w_rdata   = (address == ADDR_SUM)  ? 32'(r_sum) :
                       (address == ADDR_SW)   ? 32'(r_sw_sync) :
                       (address == ADDR_CTRL) ? 32'({r_sat, r_mode}) : 32'({r_ovf, r_count});
    assign led       = r_sum[LED_W-1:0];
    assign readdata  = r_readdata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_mode     <= MODE_ADD;
            r_sat      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_clear_pulse) begin
                r_sum   <= '0;
                r_count <= '0;
            end else if (w_wr_sum) r_sum <= writedata[DATA_W-1:0];
            else if (w_acc) begin
                r_sum   <= w_result;
                r_count <= r_count + 1'b1;
            end
            r_ovf <= (w_acc && w_carry) || (r_ovf && !w_w1c);
            if (w_wr_ctrl) begin
                r_mode <= mode_t'(writedata[1:0]);
                r_sat  <= writedata[CTRL_SAT_BIT];
            end
            if (read) r_readdata <= w_rdata;
        end
    end
endmodule

// File: tb/tb_switch_accumulator.sv
// tb_switch_accumulator: directed vector table plus hand-written multi-cycle sequences
module tb_switch_accumulator;
    import accum_pkg::*;
    typedef struct {
        logic [7:0] init;
        logic [7:0] sw;
        logic [1:0] mode;
        logic       sat;
        logic [7:0] exp_sum;
        logic       exp_ovf;
    } vec_t;
    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic key_accum_n = 1'b1, key_clear_n = 1'b1;
    logic [1:0] address = 2'd0;
    logic read = 1'b0, write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [7:0] led;
    logic [31:0] readdata;
    int checks = 0, failures = 0;
    vec_t vecs[11];
    switch_accumulator #(.DATA_W(8), .LED_W(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .sw(sw), .key_accum_n(key_accum_n), .key_clear_n(key_clear_n),
        .led(led), .address(address), .read(read), .write(write), .writedata(writedata), .readdata(readdata)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask
    task automatic press(input bit clr);
        if (clr) key_clear_n = 1'b0;
        else key_accum_n = 1'b0;
        repeat (10) @(negedge clk);
        key_clear_n = 1'b1;
        key_accum_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask
    task automatic hold_accum(input logic lvl, input int n);
        key_accum_n = lvl;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        logic [31:0] rd;
        vecs[0]  = '{8'hFE, 8'h03, MODE_ADD,  1'b0, 8'h01, 1'b1};
        vecs[1]  = '{8'hFE, 8'h03, MODE_ADD,  1'b1, 8'hFF, 1'b1};
        vecs[2]  = '{8'h02, 8'h05, MODE_SUB,  1'b1, 8'h00, 1'b1};
        vecs[3]  = '{8'h02, 8'h05, MODE_SUB,  1'b0, 8'hFD, 1'b1};
        vecs[4]  = '{8'h10, 8'h22, MODE_ADD,  1'b0, 8'h32, 1'b0};
        vecs[5]  = '{8'h50, 8'h10, MODE_SUB,  1'b0, 8'h40, 1'b0};
        vecs[6]  = '{8'hF0, 8'hFF, MODE_XOR,  1'b0, 8'h0F, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, MODE_XOR,  1'b1, 8'h00, 1'b0};
        vecs[8]  = '{8'h33, 8'h44, MODE_RSVD, 1'b0, 8'h33, 1'b0};
        vecs[9]  = '{8'h00, 8'h00, MODE_SUB,  1'b1, 8'h00, 1'b0};
        vecs[10] = '{8'hFF, 8'h01, MODE_ADD,  1'b1, 8'hFF, 1'b1};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        bus_read(ADDR_SUM, rd);    check("reset_sum", rd, 32'h0);
        bus_read(ADDR_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("reset_status", rd, 32'h0);
        sw = 8'h05;
        repeat (3) @(negedge clk);
        hold_accum(1'b0, 3);
        hold_accum(1'b1, 1);
        hold_accum(1'b0, 10);
        hold_accum(1'b1, 10);
        bus_read(ADDR_SUM, rd);    check("bounce_sum", rd, 32'h05);
        bus_read(ADDR_STATUS, rd); check("bounce_count", rd, 32'h1);
        check("bounce_led", 32'(led), 32'h05);
        for (int i = 0; i < 11; i++) begin
            bus_write(ADDR_STATUS, 32'h0001_0000);
            bus_write(ADDR_SUM, 32'(vecs[i].init));
            bus_write(ADDR_CTRL, 32'({vecs[i].sat, vecs[i].mode}));
            sw = vecs[i].sw;
            press(1'b0);
            bus_read(ADDR_SUM, rd);
            check($sformatf("vec%0d_sum", i), rd, 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_sum));
            bus_read(ADDR_STATUS, rd);
            check($sformatf("vec%0d_ovf", i), 32'(rd[16]), 32'(vecs[i].exp_ovf));
        end
        press(1'b1);
        bus_read(ADDR_SUM, rd);    check("clear_sum", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("clear_status", rd, 32'h0001_0000);
        bus_write(ADDR_STATUS, 32'h0001_0000);
        bus_read(ADDR_STATUS, rd); check("w1c_ovf", rd, 32'h0);
        bus_write(ADDR_CTRL, 32'h0);
        sw = 8'h01;
        repeat (3) @(negedge clk);
        key_accum_n = 1'b0;
        repeat (5) @(negedge clk);
        bus_write(ADDR_SUM, 32'h40);
        hold_accum(1'b0, 5);
        hold_accum(1'b1, 10);
        bus_read(ADDR_SUM, rd);    check("collide_sum", rd, 32'h40);
        bus_read(ADDR_STATUS, rd); check("collide_count", rd, 32'h0);
        sw = 8'hA5;
        repeat (3) @(negedge clk);
        address = ADDR_SUM;
        read = 1'b1;
        @(negedge clk);
        address = ADDR_SW;
        check("latency_before", readdata, 32'h40);
        @(posedge clk);
        #1 check("latency_after", readdata, 32'h0000_00A5);
        @(negedge clk);
        read = 1'b0;
        key_accum_n = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1 check("reset_async_led", 32'(led), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_accum(1'b0, 2);
        hold_accum(1'b1, 12);
        bus_read(ADDR_SUM, rd);    check("midreset_sum", rd, 32'h0);
        bus_read(ADDR_STATUS, rd); check("midreset_status", rd, 32'h0);
        check("midreset_led", 32'(led), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
